// File: rtl/fact_seq_engine.sv
// fact_seq_engine: iterative N! engine with valid/ready handshakes.
// One multiply per CALC cycle, walking the operand down from N to 2.
// The result saturates to all-ones with an overflow flag when N! does not fit in W_F bits.
module fact_seq_engine #(
  parameter int W_N = 32,
  parameter int W_F = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_N-1:0] in_n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_F-1:0] out_fact,
  output logic           out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W_F-1:0] ONE_F = {{(W_F-1){1'b0}}, 1'b1};
  localparam logic [W_N-1:0] ONE_N = {{(W_N-1){1'b0}}, 1'b1};

  state_t             state, state_d;
  logic [W_F-1:0]     acc, acc_d;
  logic [W_N-1:0]     cnt, cnt_d;
  logic               ovf, ovf_d;
  logic [W_F-1:0]     fact_q, fact_d;
  logic               fovf_q, fovf_d;
  logic [W_F+W_N-1:0] prod;

  // State and datapath registers; reset clears everything asynchronously so
  // an abandoned computation can never produce a late out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      fact_q <= '0;
      fovf_q <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      ovf    <= ovf_d;
      fact_q <= fact_d;
      fovf_q <= fovf_d;
    end
  end

  // Next-state and datapath logic; the visible result registers only change
  // on the edge that enters DONE, so they hold through IDLE and CALC.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    ovf_d   = ovf;
    fact_d  = fact_q;
    fovf_d  = fovf_q;
    prod    = {{W_N{1'b0}}, acc} * {{W_F{1'b0}}, cnt};
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_d   = ONE_F;
          cnt_d   = in_n;
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt <= ONE_N) begin
          state_d = DONE;
          fact_d  = acc;
          fovf_d  = ovf;
        end else if (prod[W_F +: W_N] == '0) begin
          acc_d = prod[W_F-1:0];
          cnt_d = cnt - ONE_N;
        end else begin
          acc_d   = '1;
          ovf_d   = 1'b1;
          state_d = DONE;
          fact_d  = '1;
          fovf_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_fact  = fact_q;
  assign out_ovf   = fovf_q;

endmodule

// File: tb/tb_fact_seq_engine.sv
// tb_fact_seq_engine: directed and randomized checks of fact_seq_engine
// against a plain-arithmetic factorial model.
module tb_fact_seq_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_n;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_fact;
  logic        out_ovf;

  int checks_total;
  int checks_passed;

  fact_seq_engine #(.W_N(32), .W_F(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fact  (out_fact),
    .out_ovf   (out_ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: n! computed by ascending multiplication in 128 bits,
  // saturating once the value no longer fits in 64 bits.
  function automatic void ref_fact(input logic [31:0] n, output logic [63:0] f, output logic o);
    logic [127:0] r;
    r = 128'd1;
    o = 1'b0;
    for (longint i = 2; i <= longint'(n); i++) begin
      r = r * 128'(i);
      if (r[127:64] != 64'd0) begin
        o = 1'b1;
        break;
      end
    end
    f = o ? 64'hFFFF_FFFF_FFFF_FFFF : r[63:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Offer n, wait for out_valid (bounded), and report edges from the accepting edge.
  task automatic applyStimulus(input logic [31:0] n, output int lat);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_n     = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_n     = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) checkOutput("timeout_out_valid", 64'(out_valid), 64'd1);
  endtask

  // Retire the current result with a one-edge out_ready pulse.
  task automatic retire;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("in_ready_after_retire", 64'(in_ready), 64'd1);
    checkOutput("out_valid_after_retire", 64'(out_valid), 64'd0);
  endtask

  // Full transaction checked against the model; latency exact without overflow.
  task automatic run_op(input logic [31:0] n);
    logic [63:0] ef;
    logic        eo;
    int          lat;
    int          elat;
    ref_fact(n, ef, eo);
    applyStimulus(n, lat);
    checkOutput("out_fact", out_fact, ef);
    checkOutput("out_ovf", 64'(out_ovf), 64'(eo));
    if (!eo) begin
      elat = (n == 0) ? 1 : int'(n);
      checkOutput("latency", 64'(lat), 64'(elat));
    end else begin
      checkOutput("ovf_latency_bound", 64'(lat <= 21), 64'd1);
    end
    retire();
  endtask

  initial begin
    int lat;
    logic [31:0] rn;
    checks_total  = 0;
    checks_passed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_n      = '0;
    out_ready = 1'b0;

    // Reset state.
    #2;
    checkOutput("rst_out_fact", out_fact, 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed: 5, 0, 1, 20, 21.
    run_op(32'd5);
    run_op(32'd0);
    run_op(32'd1);
    run_op(32'd20);
    checkOutput("held_in_idle_fact", out_fact, 64'd2432902008176640000);
    run_op(32'd21);

    // Huge operand overflows on the third multiply.
    applyStimulus(32'hFFFF_FFFF, lat);
    checkOutput("big_fact", out_fact, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("big_ovf", 64'(out_ovf), 64'd1);
    checkOutput("big_early_exit", 64'(lat <= 3), 64'd1);
    retire();

    // Backpressure: hold out_ready low for 10 cycles while wiggling inputs.
    applyStimulus(32'd7, lat);
    checkOutput("bp_latency", 64'(lat), 64'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_n     = $urandom_range(0, 12);
      checkOutput("bp_fact_stable", out_fact, 64'd5040);
      checkOutput("bp_ovf_stable", 64'(out_ovf), 64'd0);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid_high", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    retire();

    // Reset during CALC abandons the operand and clears outputs at once.
    @(negedge clk);
    in_valid = 1'b1;
    in_n     = 32'd13;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_fact", out_fact, 64'd0);
    checkOutput("midrst_out_ovf", 64'(out_ovf), 64'd0);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      checkOutput("no_valid_after_abandon", 64'(seen), 64'd0);
    end
    run_op(32'd13);
    checkOutput("fact13_held", out_fact, 64'd6227020800);

    // Randomized operands, mostly in the interesting 0..25 range.
    for (int k = 0; k < 12; k++) begin
      rn = 32'($urandom_range(0, 25));
      run_op(rn);
    end
    for (int k = 0; k < 2; k++) begin
      rn = $urandom | 32'h0000_0100;
      run_op(rn);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
